// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter
//   Two-way request arbiter in front of the page-table walker. Requestor 0
//   is the ITLB, requestor 1 the DTLB. The winning request is captured in a
//   one-entry output register, and the owner index is reported on io_chosen.
//
//   Build option:
//     PTW_ARB_RR_EN defined   : round-robin under contention (last_grant reg)
//     PTW_ARB_RR_EN undefined : fixed priority, port 0 wins under contention
//
//   Ports:
//     clock, reset          : clock, synchronous active-high reset
//     io_in_k_valid/ready   : request handshake from requestor k (k = 0,1)
//     io_in_k_bits_*        : prv/pum/mxr/addr/store/fetch of requestor k
//     io_out_valid/ready    : registered request handshake towards the PTW
//     io_out_bits_*         : fields of the held request
//     io_chosen             : index of the requestor that owns io_out_bits_*
module ptw_req_arbiter #(
  parameter int ADDR_W = 27,
  parameter int PRV_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_0_valid,
  output logic              io_in_0_ready,
  input  logic [PRV_W-1:0]  io_in_0_bits_prv,
  input  logic              io_in_0_bits_pum,
  input  logic              io_in_0_bits_mxr,
  input  logic [ADDR_W-1:0] io_in_0_bits_addr,
  input  logic              io_in_0_bits_store,
  input  logic              io_in_0_bits_fetch,
  input  logic              io_in_1_valid,
  output logic              io_in_1_ready,
  input  logic [PRV_W-1:0]  io_in_1_bits_prv,
  input  logic              io_in_1_bits_pum,
  input  logic              io_in_1_bits_mxr,
  input  logic [ADDR_W-1:0] io_in_1_bits_addr,
  input  logic              io_in_1_bits_store,
  input  logic              io_in_1_bits_fetch,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [PRV_W-1:0]  io_out_bits_prv,
  output logic              io_out_bits_pum,
  output logic              io_out_bits_mxr,
  output logic [ADDR_W-1:0] io_out_bits_addr,
  output logic              io_out_bits_store,
  output logic              io_out_bits_fetch,
  output logic              io_chosen
);

  typedef struct packed {
    logic [PRV_W-1:0]  prv;
    logic              pum;
    logic              mxr;
    logic [ADDR_W-1:0] addr;
    logic              store;
    logic              fetch;
  } req_t;

  req_t in0, in1;
  req_t bits_q, bits_d;
  logic full_q, full_d;
  logic chosen_q, chosen_d;
  logic space;
  logic win0_ok, win1_ok;
  logic grant;
  logic accept;

  assign in0 = '{prv: io_in_0_bits_prv, pum: io_in_0_bits_pum, mxr: io_in_0_bits_mxr,
                 addr: io_in_0_bits_addr, store: io_in_0_bits_store, fetch: io_in_0_bits_fetch};
  assign in1 = '{prv: io_in_1_bits_prv, pum: io_in_1_bits_pum, mxr: io_in_1_bits_mxr,
                 addr: io_in_1_bits_addr, store: io_in_1_bits_store, fetch: io_in_1_bits_fetch};

  // The register can take a new request when empty or when it drains this cycle.
  assign space = !full_q | io_out_ready;

  // winK_ok: port K would win if it presented a request now. It is built only
  // from the other port's valid, so no port's ready depends on its own valid.
`ifdef PTW_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign win0_ok = !io_in_1_valid | last_grant_q;
  assign win1_ok = !io_in_0_valid | !last_grant_q;
`else
  assign win0_ok = 1'b1;
  assign win1_ok = !io_in_0_valid;
`endif

  assign grant  = io_in_1_valid & win1_ok;
  assign accept = (io_in_0_valid | io_in_1_valid) & space;

  // A handshake during reset must not look accepted to the requestor.
  assign io_in_0_ready = !reset & space & win0_ok;
  assign io_in_1_ready = !reset & space & win1_ok;

  always_comb begin
    full_d   = full_q;
    bits_d   = bits_q;
    chosen_d = chosen_q;
`ifdef PTW_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    if (accept) begin
      full_d   = 1'b1;
      bits_d   = grant ? in1 : in0;
      chosen_d = grant;
`ifdef PTW_ARB_RR_EN
      last_grant_d = grant;
`endif
    end else if (io_out_ready) begin
      // Drain only: bits keep their last value.
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q   <= 1'b0;
      bits_q   <= '0;
      chosen_q <= 1'b0;
`ifdef PTW_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      full_q   <= full_d;
      bits_q   <= bits_d;
      chosen_q <= chosen_d;
`ifdef PTW_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign io_out_valid      = full_q;
  assign io_out_bits_prv   = bits_q.prv;
  assign io_out_bits_pum   = bits_q.pum;
  assign io_out_bits_mxr   = bits_q.mxr;
  assign io_out_bits_addr  = bits_q.addr;
  assign io_out_bits_store = bits_q.store;
  assign io_out_bits_fetch = bits_q.fetch;
  assign io_chosen         = chosen_q;

endmodule
